// File: rtl/alu_pkg.sv
// Shared widths, ALU function codes and scheduler state encoding for the ALU command path.
package alu_pkg;
  localparam int DATA_WD = 8;
  localparam int FUN_WD  = 4;
  localparam int OUT_WD  = 2 * DATA_WD;

  localparam logic [FUN_WD-1:0] ADD  = 4'd0;
  localparam logic [FUN_WD-1:0] SUB  = 4'd1;
  localparam logic [FUN_WD-1:0] MUL  = 4'd2;
  localparam logic [FUN_WD-1:0] DIV  = 4'd3;
  localparam logic [FUN_WD-1:0] MOD  = 4'd4;
  localparam logic [FUN_WD-1:0] AND  = 4'd5;
  localparam logic [FUN_WD-1:0] OR   = 4'd6;
  localparam logic [FUN_WD-1:0] XOR  = 4'd7;
  localparam logic [FUN_WD-1:0] NOT  = 4'd8;
  localparam logic [FUN_WD-1:0] NAND = 4'd9;
  localparam logic [FUN_WD-1:0] NOR  = 4'd10;
  localparam logic [FUN_WD-1:0] XNOR = 4'd11;
  localparam logic [FUN_WD-1:0] INC  = 4'd12;
  localparam logic [FUN_WD-1:0] SHR  = 4'd13;
  localparam logic [FUN_WD-1:0] SHL  = 4'd14;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    SEND_LO = 3'd3,
    SEND_HI = 3'd4
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant and the pointer value to load on acceptance.
// Combinational; ptr selects the winner only when both requesters are valid.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       ptr_nxt
);
  always_comb begin
    grant   = 2'b00;
    ptr_nxt = ptr;
    if (valid[0] && (!valid[1] || !ptr)) begin
      grant   = 2'b01;
      ptr_nxt = 1'b1;
    end else if (valid[1]) begin
      grant   = 2'b10;
      ptr_nxt = 1'b0;
    end
  end
endmodule

// File: rtl/alu_cmd_sched.sv
// Two-requester scheduler for the shared ALU: accept, issue, capture, return result as two TX bytes.
// Accept N, alu_en N+1, tx_valid N+3; requesters stall outside IDLE, TX bytes hold under tx_ready low.
module alu_cmd_sched
  import alu_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_WD-1:0] req0_a,
  input  logic [DATA_WD-1:0] req0_b,
  input  logic [FUN_WD-1:0]  req0_fun,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_WD-1:0] req1_a,
  input  logic [DATA_WD-1:0] req1_b,
  input  logic [FUN_WD-1:0]  req1_fun,
  output logic [DATA_WD-1:0] alu_a,
  output logic [DATA_WD-1:0] alu_b,
  output logic [FUN_WD-1:0]  alu_fun,
  output logic               alu_en,
  input  logic [OUT_WD-1:0]  alu_out,
  output logic [DATA_WD-1:0] tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_src,
  output logic               tx_last,
  output logic               busy
);
  state_t            state;
  logic              ptr;
  logic              ptr_nxt;
  logic [1:0]        grant;
  logic [OUT_WD-1:0] res;
  logic              accept;

  rr_arb2 u_arb (
    .valid   ({req1_valid, req0_valid}),
    .ptr     (ptr),
    .grant   (grant),
    .ptr_nxt (ptr_nxt)
  );

  // Nothing is offered while reset is held, so no request slips in on the reset edge.
  assign req0_ready = (state == IDLE) && !RST && grant[0];
  assign req1_ready = (state == IDLE) && !RST && grant[1];
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      res      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_fun  <= '0;
      alu_en   <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_src   <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      alu_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= grant[1] ? req1_a   : req0_a;
            alu_b   <= grant[1] ? req1_b   : req0_b;
            alu_fun <= grant[1] ? req1_fun : req0_fun;
            tx_src  <= grant[1];
            ptr     <= ptr_nxt;
            alu_en  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        // ALU result is registered one cycle after the enable; its valid flag is sticky, so timing is fixed instead.
        WAIT: begin
          res      <= alu_out;
          tx_data  <= alu_out[DATA_WD-1:0];
          tx_valid <= 1'b1;
          tx_last  <= 1'b0;
          state    <= SEND_LO;
        end
        SEND_LO: begin
          if (tx_ready) begin
            tx_data <= res[OUT_WD-1:DATA_WD];
            tx_last <= 1'b1;
            state   <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sched.sv
// Bench for alu_cmd_sched: behavioural ALU, event monitor, and a round-robin reference schedule.
module tb_alu_cmd_sched;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_fun = '0, req1_fun = '0;
  logic [7:0]  alu_a, alu_b, tx_data;
  logic [3:0]  alu_fun;
  logic        alu_en, tx_valid, tx_src, tx_last, busy;
  logic        tx_ready = 1'b0;
  logic [15:0] alu_out = '0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct packed {logic [7:0] a; logic [7:0] b; logic [3:0] fun;} op_t;
  typedef struct {int c; logic src;} acc_t;
  typedef struct {int c; logic [7:0] d; logic last; logic src;} txb_t;
  typedef struct {logic src; logic [15:0] res;} exp_t;

  op_t  q0[$], q1[$];
  acc_t acc_q[$];
  txb_t tx_q[$];
  int   en_q[$];
  exp_t exp_q[$];

  alu_cmd_sched dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en), .alu_out(alu_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_src(tx_src), .tx_last(tx_last),
    .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (f)
      ADD:  return wa + wb;
      SUB:  return wa - wb;
      MUL:  return wa * wb;
      DIV:  return (b == 8'h00) ? 16'h0000 : wa / wb;
      MOD:  return (b == 8'h00) ? 16'h0000 : wa % wb;
      AND:  return wa & wb;
      OR:   return wa | wb;
      XOR:  return wa ^ wb;
      NOT:  return {8'h00, ~a};
      NAND: return {8'h00, ~(a & b)};
      NOR:  return {8'h00, ~(a | b)};
      XNOR: return {8'h00, ~(a ^ b)};
      INC:  return wa + 16'd1;
      SHR:  return wa >> b[3:0];
      SHL:  return wa << b[3:0];
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural ALU: one-cycle registered result, held after the enable drops.
  always @(posedge CLK) if (alu_en) alu_out <= alu_ref(alu_a, alu_b, alu_fun);

  always @(negedge CLK) begin
    if (req0_valid && req0_ready) acc_q.push_back('{c: cyc, src: 1'b0});
    if (req1_valid && req1_ready) acc_q.push_back('{c: cyc, src: 1'b1});
    if (alu_en) en_q.push_back(cyc);
    if (tx_valid && tx_ready) tx_q.push_back('{c: cyc, d: tx_data, last: tx_last, src: tx_src});
  end

  function automatic op_t rand_op();
    op_t o;
    o.a   = 8'($urandom);
    o.b   = 8'($urandom);
    o.fun = 4'($urandom_range(0, 15));
    return o;
  endfunction

  // Reference schedule: both pending -> pointer's choice; otherwise the only one pending; pointer moves to the loser.
  task automatic build_model();
    op_t m0[$], m1[$], o;
    logic p, g;
    m0 = q0;
    m1 = q1;
    p  = 1'b0;
    exp_q.delete();
    while (m0.size() + m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) g = p;
      else g = (m1.size() > 0);
      if (g) o = m1.pop_front();
      else o = m0.pop_front();
      exp_q.push_back('{src: g, res: alu_ref(o.a, o.b, o.fun)});
      p = ~g;
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    acc_q.delete(); tx_q.delete(); en_q.delete(); q0.delete(); q1.delete();
  endtask

  // Requesters keep valid high whenever they have queued work; returns ok=0 on cycle-budget expiry.
  task automatic run_ops(input bit rnd_rdy, input int budget, output bit ok);
    bit hs0, hs1;
    int n;
    hs0 = 1'b0; hs1 = 1'b0; n = 0; ok = 1'b0;
    while (n < budget) begin
      @(posedge CLK); #1;
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
      req0_valid = (q0.size() > 0);
      req1_valid = (q1.size() > 0);
      if (q0.size() > 0) {req0_a, req0_b, req0_fun} = q0[0];
      if (q1.size() > 0) {req1_a, req1_b, req1_fun} = q1[0];
      tx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLK);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (q0.size() == 0 && q1.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic check_against_model(input string nm);
    total_cnt++;
    if (tx_q.size() !== 2 * exp_q.size() || acc_q.size() !== exp_q.size() || en_q.size() !== exp_q.size()) begin
      $display("FAIL %s_counts: got acc=%0d en=%0d tx=%0d want ops=%0d bytes=%0d", nm,
               acc_q.size(), en_q.size(), tx_q.size(), exp_q.size(), 2 * exp_q.size());
    end else begin
      pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
        total_cnt++;
        if (acc_q[i].src !== exp_q[i].src) $display("FAIL %s_grant%0d: got %0d want %0d", nm, i, acc_q[i].src, exp_q[i].src);
        else pass_cnt++;
        total_cnt++;
        if ({tx_q[2*i].d, tx_q[2*i].last, tx_q[2*i].src} !== {exp_q[i].res[7:0], 1'b0, exp_q[i].src})
          $display("FAIL %s_lo%0d: got d=%h last=%0d src=%0d want d=%h last=0 src=%0d", nm, i,
                   tx_q[2*i].d, tx_q[2*i].last, tx_q[2*i].src, exp_q[i].res[7:0], exp_q[i].src);
        else pass_cnt++;
        total_cnt++;
        if ({tx_q[2*i+1].d, tx_q[2*i+1].last, tx_q[2*i+1].src} !== {exp_q[i].res[15:8], 1'b1, exp_q[i].src})
          $display("FAIL %s_hi%0d: got d=%h last=%0d src=%0d want d=%h last=1 src=%0d", nm, i,
                   tx_q[2*i+1].d, tx_q[2*i+1].last, tx_q[2*i+1].src, exp_q[i].res[15:8], exp_q[i].src);
        else pass_cnt++;
        total_cnt++;
        if (en_q[i] !== acc_q[i].c + 1) $display("FAIL %s_en%0d: got cycle %0d want %0d", nm, i, en_q[i], acc_q[i].c + 1);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; tx_ready = 1'b1;
    req0_a = 8'hAA; req1_b = 8'h55;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total_cnt++;
    if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    else pass_cnt++;
    total_cnt++;
    if ({alu_en, tx_valid, tx_last, tx_src, busy} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {alu_en, tx_valid, tx_last, tx_src, busy});
    else pass_cnt++;
    total_cnt++;
    if ({alu_a, alu_b, alu_fun, tx_data} !== 28'h0) $display("FAIL reset_data: got %h want 0", {alu_a, alu_b, alu_fun, tx_data});
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_single_op();
    bit ok;
    do_reset();
    q0.push_back('{a: 8'h12, b: 8'h34, fun: ADD});
    run_ops(1'b0, 100, ok);
    total_cnt++;
    if (!ok) $display("FAIL single_timeout: got timeout want completion");
    else pass_cnt++;
    total_cnt++;
    if (tx_q.size() !== 2 || acc_q.size() !== 1 || en_q.size() !== 1)
      $display("FAIL single_counts: got tx=%0d acc=%0d en=%0d want 2 1 1", tx_q.size(), acc_q.size(), en_q.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if ({tx_q[0].d, tx_q[0].last, tx_q[0].src} !== {8'h46, 1'b0, 1'b0})
        $display("FAIL single_lo: got %h/%0d/%0d want 46/0/0", tx_q[0].d, tx_q[0].last, tx_q[0].src);
      else pass_cnt++;
      total_cnt++;
      if ({tx_q[1].d, tx_q[1].last, tx_q[1].src} !== {8'h00, 1'b1, 1'b0})
        $display("FAIL single_hi: got %h/%0d/%0d want 00/1/0", tx_q[1].d, tx_q[1].last, tx_q[1].src);
      else pass_cnt++;
      total_cnt++;
      if (en_q[0] !== acc_q[0].c + 1) $display("FAIL single_en_lat: got %0d want %0d", en_q[0] - acc_q[0].c, 1);
      else pass_cnt++;
      total_cnt++;
      if (tx_q[0].c !== acc_q[0].c + 3) $display("FAIL single_tx_lat: got %0d want %0d", tx_q[0].c - acc_q[0].c, 3);
      else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [7:0] eb [4];
    logic [1:0] es [4];
    eb = '{8'h01, 8'hFE, 8'hFE, 8'hFF};
    es = '{2'b00, 2'b10, 2'b01, 2'b11};
    do_reset();
    q0.push_back('{a: 8'hFF, b: 8'hFF, fun: MUL});
    q1.push_back('{a: 8'h05, b: 8'h07, fun: SUB});
    run_ops(1'b0, 100, ok);
    total_cnt++;
    if (!ok || tx_q.size() !== 4 || acc_q.size() !== 2)
      $display("FAIL contention_counts: got ok=%0d tx=%0d acc=%0d want 1 4 2", ok, tx_q.size(), acc_q.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if ({acc_q[0].src, acc_q[1].src} !== 2'b01) $display("FAIL contention_order: got %0d,%0d want 0,1", acc_q[0].src, acc_q[1].src);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
        total_cnt++;
        if ({tx_q[i].d, tx_q[i].last, tx_q[i].src} !== {eb[i], es[i]})
          $display("FAIL contention_byte%0d: got %h/%0d/%0d want %h/%0d/%0d", i,
                   tx_q[i].d, tx_q[i].last, tx_q[i].src, eb[i], es[i][0], es[i][1]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    do_reset();
    @(posedge CLK); #1;
    {req0_a, req0_b, req0_fun} = {8'h1F, 8'h23, MUL};
    {req1_a, req1_b, req1_fun} = {8'h77, 8'h01, ADD};
    req0_valid = 1'b1; req1_valid = 1'b1; tx_ready = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if (!req0_ready || req1_ready) $display("FAIL bp_accept: got r0=%0d r1=%0d want 1 0", req0_ready, req1_ready);
    else pass_cnt++;
    @(posedge CLK); #1 req0_valid = 1'b0;
    w = 0;
    while (!tx_valid && w < 10) begin @(negedge CLK); w++; end
    total_cnt++;
    if (w >= 10) $display("FAIL bp_tx_timeout: got no tx_valid want tx_valid within 10 cycles");
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if ({tx_valid, tx_data, tx_last, tx_src, req0_ready, req1_ready} !== {1'b1, 8'h3D, 4'b0000})
        $display("FAIL bp_lo_hold%0d: got v=%0d d=%h last=%0d src=%0d rdy=%0d%0d want 1 3D 0 0 00", k,
                 tx_valid, tx_data, tx_last, tx_src, req0_ready, req1_ready);
      else pass_cnt++;
      @(posedge CLK); #1;
      if (k == 3) tx_ready = 1'b1;
      @(negedge CLK);
    end
    @(posedge CLK); #1 tx_ready = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if ({tx_valid, tx_data, tx_last, tx_src, req0_ready, req1_ready} !== {1'b1, 8'h04, 4'b1000})
        $display("FAIL bp_hi_hold%0d: got v=%0d d=%h last=%0d src=%0d rdy=%0d%0d want 1 04 1 0 00", k,
                 tx_valid, tx_data, tx_last, tx_src, req0_ready, req1_ready);
      else pass_cnt++;
      @(posedge CLK); #1;
      if (k == 1) begin tx_ready = 1'b1; req1_valid = 1'b0; end
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    total_cnt++;
    if (tx_valid || busy) $display("FAIL bp_done: got tx_valid=%0d busy=%0d want 0 0", tx_valid, busy);
    else pass_cnt++;
    total_cnt++;
    if (tx_q.size() !== 2) $display("FAIL bp_bytes: got %0d bytes want 2", tx_q.size());
    else if ({tx_q[0].d, tx_q[1].d} !== 16'h3D04) $display("FAIL bp_bytes: got %h %h want 3D 04", tx_q[0].d, tx_q[1].d);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    build_model();
    run_ops(1'b0, 200, ok);
    total_cnt++;
    if (!ok) $display("FAIL fair_timeout: got timeout want completion");
    else pass_cnt++;
    check_against_model("fair");
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      total_cnt++;
      if (acc_q[i].src !== (i % 2 == 1)) $display("FAIL fair_alt%0d: got %0d want %0d", i, acc_q[i].src, i % 2);
      else pass_cnt++;
      if (i > 0) begin
        total_cnt++;
        if (acc_q[i].c !== acc_q[i-1].c + 5) $display("FAIL fair_b2b%0d: got gap %0d want 5", i, acc_q[i].c - acc_q[i-1].c);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_div_unsup();
    bit ok;
    do_reset();
    q0.push_back('{a: 8'h09, b: 8'h00, fun: DIV});
    q1.push_back('{a: 8'hA5, b: 8'h3C, fun: 4'hF});
    run_ops(1'b0, 100, ok);
    total_cnt++;
    if (!ok || tx_q.size() !== 4) $display("FAIL divz_counts: got ok=%0d tx=%0d want 1 4", ok, tx_q.size());
    else begin
      pass_cnt++;
      for (int i = 0; i < 4; i++) begin
        total_cnt++;
        if ({tx_q[i].d, tx_q[i].last, tx_q[i].src} !== {8'h00, (i % 2 == 1), (i >= 2)})
          $display("FAIL divz_byte%0d: got %h/%0d/%0d want 00/%0d/%0d", i, tx_q[i].d, tx_q[i].last, tx_q[i].src, i % 2, i / 2);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    @(posedge CLK); #1;
    {req1_a, req1_b, req1_fun} = {8'h5A, 8'h11, XOR};
    req1_valid = 1'b1; tx_ready = 1'b1;
    @(negedge CLK);
    total_cnt++;
    if (!req1_ready) $display("FAIL rstw_accept: got %0d want 1", req1_ready);
    else pass_cnt++;
    @(posedge CLK); #1 req1_valid = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if (!alu_en || alu_a !== 8'h5A || !tx_src) $display("FAIL rstw_issue: got en=%0d a=%h src=%0d want 1 5A 1", alu_en, alu_a, tx_src);
    else pass_cnt++;
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if ({alu_a, alu_b, alu_fun, tx_data, alu_en, tx_valid, tx_last, tx_src, busy} !== 33'h0)
      $display("FAIL rstw_outputs: got a=%h b=%h f=%h d=%h en=%0d v=%0d last=%0d src=%0d busy=%0d want all 0",
               alu_a, alu_b, alu_fun, tx_data, alu_en, tx_valid, tx_last, tx_src, busy);
    else pass_cnt++;
    repeat (6) @(negedge CLK);
    total_cnt++;
    if (tx_q.size() !== 0) $display("FAIL rstw_no_tx: got %0d bytes want 0", tx_q.size());
    else pass_cnt++;

    @(posedge CLK); #1;
    {req0_a, req0_b, req0_fun} = {8'h80, 8'h03, MUL};
    req0_valid = 1'b1; tx_ready = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if (!req0_ready) $display("FAIL rsth_accept: got %0d want 1", req0_ready);
    else pass_cnt++;
    @(posedge CLK); #1 req0_valid = 1'b0;
    w = 0;
    while (!tx_valid && w < 10) begin @(negedge CLK); w++; end
    @(posedge CLK); #1 tx_ready = 1'b1;
    @(posedge CLK); #1 tx_ready = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if (w >= 10 || !tx_valid || !tx_last || tx_data !== 8'h01)
      $display("FAIL rsth_in_hi: got wait=%0d v=%0d last=%0d d=%h want <10 1 1 01", w, tx_valid, tx_last, tx_data);
    else pass_cnt++;
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge CLK);
    total_cnt++;
    if ({alu_a, alu_b, alu_fun, tx_data, alu_en, tx_valid, tx_last, tx_src, busy} !== 33'h0)
      $display("FAIL rsth_outputs: got a=%h b=%h f=%h d=%h en=%0d v=%0d last=%0d src=%0d busy=%0d want all 0",
               alu_a, alu_b, alu_fun, tx_data, alu_en, tx_valid, tx_last, tx_src, busy);
    else pass_cnt++;
    total_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rsth_ptr: got r0=%0d r1=%0d want 1 0", req0_ready, req1_ready);
    else pass_cnt++;
    total_cnt++;
    if (tx_q.size() !== 1) $display("FAIL rsth_partial: got %0d bytes want 1", tx_q.size());
    else pass_cnt++;
    @(posedge CLK); #1 req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_random_traffic(input int iter);
    bit ok;
    int n0, n1;
    do_reset();
    n0 = $urandom_range(1, 5);
    n1 = $urandom_range(0, 5);
    for (int i = 0; i < n0; i++) q0.push_back(rand_op());
    for (int i = 0; i < n1; i++) q1.push_back(rand_op());
    build_model();
    run_ops(1'b1, 2000, ok);
    total_cnt++;
    if (!ok) $display("FAIL rand%0d_timeout: got timeout want completion", iter);
    else pass_cnt++;
    check_against_model($sformatf("rand%0d", iter));
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_fairness();
    test_div_unsup();
    test_reset_mid();
    for (int i = 0; i < 4; i++) test_random_traffic(i);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sched.md
# alu_cmd_sched

Two-requester command scheduler for the shared 8-bit ALU. It arbitrates round-robin between two operation requesters, registers the operands and function code, and pulses the ALU enable for one cycle. It then captures the 16-bit result after the ALU's one-cycle registered latency and returns it as two bytes on a single byte-wide handshake output toward the UART TX framer. The block sits between the command decoders and the ALU/TX path and is the only driver of the ALU inputs.

## Interface
- DATA_WD, 8, operand and TX byte width
- FUN_WD, 4, ALU function-code width
- OUT_WD, 16, ALU result width; must equal 2*DATA_WD

- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester n has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  DATA_WD  operands
- req0_fun / req1_fun  in  FUN_WD  ALU function code, passed through unmodified
- alu_a, alu_b  out  DATA_WD  registered operands to ALU
- alu_fun  out  FUN_WD  registered function code to ALU
- alu_en  out  1  one-cycle ALU enable pulse
- alu_out  in  OUT_WD  ALU registered result
- tx_data  out  DATA_WD  result byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts byte
- tx_src  out  1  id of requester that owns the current result
- tx_last  out  1  high with the high byte
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, SEND_LO, SEND_HI.
- IDLE: req_ready asserted combinationally only for the granted requester. Grant goes to the only valid requester; if both are valid, it goes to the requester selected by the priority pointer `ptr`. On handshake: latch a/b/fun into alu_a/alu_b/alu_fun, latch src, flip `ptr` to the non-granted requester, go to ISSUE.
- ISSUE: alu_en=1 for exactly this cycle; go to WAIT.
- WAIT: alu_out now holds the result. Capture it into result register `res`; go to SEND_LO. ALU OUT_VALID is not used, because it stays high after the enable drops.
- SEND_LO: tx_valid=1, tx_data=res[DATA_WD-1:0], tx_last=0. Hold until tx_ready, then go to SEND_HI.
- SEND_HI: tx_valid=1, tx_data=res[OUT_WD-1:DATA_WD], tx_last=1. On tx_ready go to IDLE.
- No request is accepted outside IDLE; both req_ready are 0.
- Requesters must hold valid and payload stable until ready. The block does not check this.
- Function codes are not filtered. An unsupported code (4'hF) yields 0x0000 from the ALU and is still returned as two bytes.

## Timing
- Reset values: req*_ready=0, alu_a=alu_b=0, alu_fun=0, alu_en=0, tx_data=0, tx_valid=0, tx_src=0, tx_last=0, busy=0, state=IDLE, ptr=0 (req0 favoured), res=0.
- Handshake in cycle N: alu_en=1 in N+1, capture at end of N+2, tx_valid first high in N+3.
- Minimum turnaround is 5 cycles per operation with tx_ready tied high. The next acceptance is possible in N+5.
- alu_a/alu_b/alu_fun/tx_src hold their values until the next acceptance.
- tx_data, tx_last and tx_src are stable while tx_valid=1 and tx_ready=0.
- RST during any state: synchronous return to IDLE with reset values on the next edge. Any in-flight result is discarded, and no partial byte pair is completed.
- Simultaneous valid on both requesters with ptr=0: req0 wins, ptr becomes 1, and req1 wins the next contention.

## Structure
- Shared package alu_pkg holds: the ALU function-code localparams (ADD=0 … SHL=14), the state encoding, and the widths DATA_WD/FUN_WD/OUT_WD.
- One sub-module: rr_arb2, a 2-way round-robin arbiter. It takes the valids and the pointer and outputs a one-hot grant and the pointer update. The FSM, operand/result registers and TX mux live in alu_cmd_sched.

## Test plan
- Single op: req0 A=0x12, B=0x34, fun=0 (ADD), tx_ready=1. Expect alu_en one cycle, then tx bytes 0x46, 0x00 with tx_last on the second, tx_src=0, tx_valid 3 cycles after accept.
- Contention: both valid from reset; req0 MUL 0xFF*0xFF, req1 SUB 0x05-0x07. Expect req0 served first with bytes 0x01, 0xFE, then req1 with bytes 0xFE, 0xFF and tx_src=1.
- Backpressure: tx_ready low for 4 cycles in SEND_LO and 2 in SEND_HI. Expect tx_data/tx_last held stable, no new req_ready, and correct bytes delivered.
- Fairness: both valid continuously for 6 ops. Expect grants alternate 0,1,0,1,0,1.
- Division by zero and unsupported code: DIV 0x09/0x00 and fun=0xF. Expect bytes 0x00, 0x00 for both.
- Reset mid-op: assert RST in WAIT, then in SEND_HI. Expect all outputs at reset values next cycle, no further tx bytes, and ptr=0.
